// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: loads a multi-beat instruction over a req/ack
// memory handshake, then steps an execution counter until the decoder ends the instruction.
module instr_sequencer #(
   parameter int               MEM_W    = 8,
   parameter int               IR_BEATS = 2,
   parameter int               ADDR_W   = 8,
   parameter int               OP_W     = 4,
   parameter int               STEP_W   = 3,
   parameter logic [OP_W-1:0]  HALT_OP  = 4'hF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic                      mem_req,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic                      mem_ack,
   input  logic [MEM_W-1:0]          mem_rdata,
   output logic [MEM_W*IR_BEATS-1:0] ir,
   output logic                      ir_valid,
   output logic [OP_W-1:0]           op,
   output logic [STEP_W-1:0]         exec_step,
   input  logic                      exec_last,
   input  logic                      pc_load,
   input  logic [ADDR_W-1:0]         pc_target,
   output logic [ADDR_W-1:0]         pc,
   input  logic                      run,
   output logic                      halted,
   output logic                      step_ovf,
   output logic [2:0]                dbg_state
);

   localparam int IR_W   = MEM_W * IR_BEATS;
   localparam int BEAT_W = (IR_BEATS > 1) ? $clog2(IR_BEATS) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      HALT   = 3'd4
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [BEAT_W-1:0] beat;
   logic              last_beat;
   logic              step_max;

   // Memory handshake: mem_req rises in FETCH and holds mem_addr stable until
   // mem_ack; a beat transfers on every cycle where both are high, including
   // an ack in the same cycle the request first appears.
   assign mem_req   = (state == FETCH);
   assign mem_addr  = mem_req ? pc : '0;
   assign ir_valid  = (state == DECODE) || (state == EXEC);
   assign op        = ir[IR_W-1 -: OP_W];
   assign halted    = (state == HALT);
   assign dbg_state = state;

   assign last_beat = (beat == BEAT_W'(IR_BEATS - 1));
   assign step_max  = (exec_step == {STEP_W{1'b1}});

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = FETCH;
         FETCH:   if (mem_ack && last_beat) state_n = DECODE;
         DECODE:  state_n = (op == HALT_OP) ? HALT : EXEC;
         EXEC:    if (exec_last || step_max) state_n = FETCH;
         HALT:    if (run) state_n = FETCH;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         ir        <= '0;
         beat      <= '0;
         exec_step <= '0;
         step_ovf  <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            FETCH: begin
               if (mem_ack) begin
                  for (int b = 0; b < IR_BEATS; b++) begin
                     if (beat == BEAT_W'(b)) ir[b*MEM_W +: MEM_W] <= mem_rdata;
                  end
                  pc   <= pc + ADDR_W'(1);
                  beat <= last_beat ? '0 : beat + BEAT_W'(1);
               end
            end
            DECODE: exec_step <= '0;
            EXEC: begin
               if (pc_load) pc <= pc_target;
               // Counter wraps to zero on overflow so the next instruction starts at T0.
               if (exec_last) begin
                  exec_step <= '0;
               end else begin
                  exec_step <= exec_step + STEP_W'(1);
                  if (step_max) step_ovf <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: an instruction-level model schedules
// each instruction's cycles and queues the expected outputs for every cycle.
module tb_instr_sequencer;

   logic        clock;
   logic        reset;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic [15:0] ir;
   logic        ir_valid;
   logic [3:0]  op;
   logic [2:0]  exec_step;
   logic        exec_last;
   logic        pc_load;
   logic [7:0]  pc_target;
   logic [7:0]  pc;
   logic        run;
   logic        halted;
   logic        step_ovf;
   logic [2:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   logic [42:0] exp_q[$];

   logic [7:0]  m_pc;
   logic [15:0] m_ir;
   logic        m_ovf;

   instr_sequencer dut (
      .clock(clock), .reset(reset),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ir(ir), .ir_valid(ir_valid), .op(op), .exec_step(exec_step), .exec_last(exec_last),
      .pc_load(pc_load), .pc_target(pc_target), .pc(pc), .run(run), .halted(halted),
      .step_ovf(step_ovf), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [7:0] r8();
      return 8'($urandom);
   endfunction

   // Expected output vector for one cycle, from the model's architectural state.
   function automatic logic [42:0] expv(input logic req, input logic iv, input logic [2:0] st,
                                        input logic hl);
      return {req, req ? m_pc : 8'h00, m_ir, iv, m_ir[15:12], st, m_pc, hl, m_ovf};
   endfunction

   task automatic m_reset();
      m_pc  = 8'h00;
      m_ir  = 16'h0000;
      m_ovf = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // scoreboard: one expected vector per cycle, compared on the falling edge
   always @(negedge clock) begin
      logic [42:0] e;
      logic [42:0] a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {mem_req, mem_addr, ir, ir_valid, op, exec_step, pc, halted, step_ovf};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL cycle_outputs at %0t actual=%h required=%h (req,addr,ir,irv,op,step,pc,halt,ovf)",
                     $time, a, e);
         end
      end
   end

   // driver: one call = one clock cycle; inputs applied just after the rising edge
   task automatic slot(input bit chk, input logic rst, input logic ack, input logic [7:0] rd,
                       input logic lst, input logic ld, input logic [7:0] tg, input logic rn,
                       input logic [42:0] e);
      @(posedge clock);
      #1;
      reset     = rst;
      mem_ack   = ack;
      mem_rdata = rd;
      exec_last = lst;
      pc_load   = ld;
      pc_target = tg;
      run       = rn;
      if (chk) exp_q.push_back(e);
   endtask

   task automatic idle_slot();
      slot(1'b1, 1'b0, rb(), r8(), rb(), rb(), r8(), rb(), expv(1'b0, 1'b0, 3'd0, 1'b0));
   endtask

   // One whole instruction: fetch beats with waits, decode, then exec or halt.
   // abort = slot index at which reset is asserted (-1 for none).
   task automatic do_instr(input logic [15:0] word, input int wfix, input int n, input int br,
                           input logic [7:0] tgt, input int abort, input bit fl, input int hold,
                           output int fc, output bit ab);
      int   k;
      int   w;
      int   h;
      logic rst;
      logic a;
      k  = 0;
      fc = 0;
      ab = 1'b0;
      for (int b = 0; b < 2; b++) begin
         w = (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
         for (int i = 0; i <= w; i++) begin
            a   = (i == w);
            rst = (k == abort);
            k++;
            fc++;
            slot(1'b1, rst, a, a ? word[b*8 +: 8] : r8(), rb(), fl ? 1'b1 : rb(), r8(), rb(),
                 expv(1'b1, 1'b0, 3'd0, 1'b0));
            if (rst) begin m_reset(); ab = 1'b1; return; end
            if (a) begin
               m_ir[b*8 +: 8] = word[b*8 +: 8];
               m_pc = m_pc + 8'd1;
            end
         end
      end
      rst = (k == abort);
      k++;
      slot(1'b1, rst, rb(), r8(), rb(), rb(), r8(), rb(), expv(1'b0, 1'b1, 3'd0, 1'b0));
      if (rst) begin m_reset(); ab = 1'b1; return; end
      if (word[15:12] == 4'hF) begin
         h = (hold >= 0) ? hold : int'($urandom_range(0, 4));
         for (int i = 0; i <= h; i++) begin
            rst = (k == abort);
            k++;
            slot(1'b1, rst, rb(), r8(), rb(), rb(), r8(), (i == h), expv(1'b0, 1'b0, 3'd0, 1'b1));
            if (rst) begin m_reset(); ab = 1'b1; return; end
         end
         return;
      end
      for (int t = 0; t < 8; t++) begin
         rst = (k == abort);
         k++;
         slot(1'b1, rst, rb(), r8(), (t == n - 1), (t == br), tgt, rb(),
              expv(1'b0, 1'b1, 3'(t), 1'b0));
         if (rst) begin m_reset(); ab = 1'b1; return; end
         if (t == br) m_pc = tgt;
         if (t == n - 1) return;
         if (t == 7) m_ovf = 1'b1;
      end
   endtask

   initial begin
      logic [15:0] word;
      int          n;
      int          br;
      int          ab_at;
      int          fc;
      bit          ab;
      reset     = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      exec_last = 1'b0;
      pc_load   = 1'b0;
      pc_target = 8'h00;
      run       = 1'b0;
      m_reset();

      slot(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, '0);
      idle_slot();
      check("reset_pc", 32'(pc), 32'h00);
      check("reset_ir", 32'(ir), 32'h0000);
      check("reset_req", 32'(mem_req), 32'h0);

      // zero-wait fetch of 0x21,0x13, last at T1
      do_instr(16'h1321, 0, 2, -1, 8'h00, -1, 1'b0, 0, fc, ab);
      check("t1_model_ir", 32'(m_ir), 32'h1321);
      check("t1_ir", 32'(ir), 32'h1321);
      check("t1_op", 32'(op), 32'h1);
      check("t1_pc", 32'(pc), 32'h02);
      check("t1_fetch_len", 32'(fc), 32'd2);

      // three wait cycles per beat
      do_instr(16'h1321, 3, 1, -1, 8'h00, -1, 1'b0, 0, fc, ab);
      check("t2_fetch_len", 32'(fc), 32'd8);
      check("t2_ir", 32'(ir), 32'h1321);

      // branch with exec_last, then pc_load held high through a fetch
      do_instr(16'h2345, 0, 2, 1, 8'h40, -1, 1'b0, 0, fc, ab);
      check("t3_model_pc", 32'(m_pc), 32'h40);
      do_instr(16'h0102, 1, 1, -1, 8'h00, -1, 1'b1, 0, fc, ab);
      check("t3_pc", 32'(pc), 32'h42);

      // halt for ten cycles, then run
      do_instr(16'hF0AA, 0, 1, -1, 8'h00, -1, 1'b0, 10, fc, ab);
      check("t4_halted", 32'(halted), 32'h1);
      check("t4_pc", 32'(pc), 32'h44);

      // exec_last never arrives
      do_instr(16'h3000, 0, 9, -1, 8'h00, -1, 1'b0, 0, fc, ab);
      check("t5_model_ovf", 32'(m_ovf), 32'h1);
      check("t5_step", 32'(exec_step), 32'd7);

      // pc wrap, then reset mid-fetch and mid-exec
      do_instr(16'h4000, 0, 1, 0, 8'hFF, -1, 1'b0, 0, fc, ab);
      do_instr(16'h5000, 0, 1, -1, 8'h00, -1, 1'b0, 0, fc, ab);
      check("t6_wrap_pc", 32'(pc), 32'h01);
      check("t6_ovf_sticky", 32'(step_ovf), 32'h1);
      do_instr(16'h6789, 0, 3, -1, 8'h00, 1, 1'b0, 0, fc, ab);
      idle_slot();
      check("t6_fetch_rst_ir", 32'(ir), 32'h0000);
      check("t6_fetch_rst_pc", 32'(pc), 32'h00);
      check("t6_fetch_rst_ovf", 32'(step_ovf), 32'h0);
      do_instr(16'h6789, 0, 3, -1, 8'h00, 4, 1'b0, 0, fc, ab);
      idle_slot();
      check("t6_exec_rst_ir", 32'(ir), 32'h0000);
      check("t6_exec_rst_pc", 32'(pc), 32'h00);

      // randomized instruction stream
      for (int i = 0; i < 150; i++) begin
         word  = 16'($urandom);
         n     = int'($urandom_range(1, 9));
         br    = int'($urandom_range(0, 9));
         ab_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
         do_instr(word, -1, n, br, r8(), ab_at, 1'b0, -1, fc, ab);
         if (ab) idle_slot();
      end

      @(negedge clock);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
